// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the ID/EX shift issue stage.
// Consumed by shift_decode, shift_issue_stage and the future hazard unit.
package shift_pkg;

    localparam int INSTR_W   = 32;
    localparam int OPC_W     = 6;
    localparam int SHAMT_W   = 5;
    localparam int SHIFTOP_W = 3;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    localparam logic [SHIFTOP_W-1:0] SHIFTOP_SLL  = 3'b000;
    localparam logic [SHIFTOP_W-1:0] SHIFTOP_SRL  = 3'b010;
    localparam logic [SHIFTOP_W-1:0] SHIFTOP_SRA  = 3'b011;
    localparam logic [SHIFTOP_W-1:0] SHIFTOP_SLLV = 3'b100;
    localparam logic [SHIFTOP_W-1:0] SHIFTOP_SRLV = 3'b110;
    localparam logic [SHIFTOP_W-1:0] SHIFTOP_SRAV = 3'b111;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/shift_issue_stage_if.sv
// Upstream (decode) and downstream (shifter) handshake bundle of the shift issue stage.
// master = environment side, slave = the stage itself.
interface shift_issue_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [DW-1:0] in_rs_data;
    logic [DW-1:0] in_rt_data;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_rs;
    logic [DW-1:0] out_rt;
    logic [4:0]    out_shamt;
    logic [2:0]    out_shiftop;
    logic [RW-1:0] out_rd;

    modport master (
        output in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
        input  in_ready, out_valid, out_rs, out_rt, out_shamt, out_shiftop, out_rd
    );

    modport slave (
        input  in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
        output in_ready, out_valid, out_rs, out_rt, out_shamt, out_shiftop, out_rd
    );
endinterface

// File: rtl/shift_issue_stage_decode.sv
// Combinational shift-class decode of a raw R-type word; shared with the hazard unit.
module shift_decode
    import shift_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [INSTR_W-1:0]   instr_i,
    output logic                 is_shift_o,
    output logic                 is_nop_o,
    output logic [SHIFTOP_W-1:0] shiftop_o,
    output logic [SHAMT_W-1:0]   shamt_o,
    output logic [RW-1:0]        rd_o
);
    logic [OPC_W-1:0] opcode;
    logic [5:0]       funct;

    assign opcode    = instr_i[31:26];
    assign funct     = instr_i[5:0];
    assign is_nop_o  = (instr_i == '0);
    assign shiftop_o = funct[2:0];
    assign shamt_o   = instr_i[10:6];
    assign rd_o      = RW'(instr_i[15:11]);

    always_comb begin
        is_shift_o = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
                FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: is_shift_o = 1'b1;
                default:                            is_shift_o = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/shift_issue_stage.sv
// ID/EX shift issue stage: decode-qualify, 2-entry skid buffer, registered ready.
// Build option SHIFT_FWD_EN adds the EX/MEM writeback bypass onto captured/buffered operands.
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    shift_issue_stage_if.slave  bus,
    output logic                drop_pulse
`ifdef SHIFT_FWD_EN
    ,
    input  logic                fwd_we,
    input  logic [RW-1:0]       fwd_rd,
    input  logic [DW-1:0]       fwd_data
`endif
);
    typedef struct packed {
        logic [DW-1:0]        rs;
        logic [DW-1:0]        rt;
        logic [SHAMT_W-1:0]   shamt;
        logic [SHIFTOP_W-1:0] shiftop;
        logic [RW-1:0]        rd;
`ifdef SHIFT_FWD_EN
        logic [RW-1:0]        rs_idx;
        logic [RW-1:0]        rt_idx;
`endif
    } entry_t;

    buf_state_e state_q;
    logic       out_valid_q, in_ready_q, drop_q;
    entry_t     out_q, skid_q;
    entry_t     new_raw, new_d, out_fw, skid_fw;

    logic                 dec_is_shift, dec_is_nop;
    logic [SHIFTOP_W-1:0] dec_shiftop;
    logic [SHAMT_W-1:0]   dec_shamt;
    logic [RW-1:0]        dec_rd;
    logic                 issue_ok, acc, push, pop, drop_d;

    shift_decode #(.RW(RW)) u_dec (
        .instr_i    (bus.in_instr),
        .is_shift_o (dec_is_shift),
        .is_nop_o   (dec_is_nop),
        .shiftop_o  (dec_shiftop),
        .shamt_o    (dec_shamt),
        .rd_o       (dec_rd)
    );

    // instr==0 decodes as SLL $0,$0,0 but must be dropped like any non-shift
    assign issue_ok = dec_is_shift && !dec_is_nop;
    assign acc      = bus.in_valid && in_ready_q && !flush;
    assign push     = acc && issue_ok;
    assign drop_d   = acc && !issue_ok;
    assign pop      = out_valid_q && bus.out_ready;

`ifdef SHIFT_FWD_EN
    function automatic entry_t fwd_apply(input entry_t e, input logic we,
                                         input logic [RW-1:0] rd, input logic [DW-1:0] data);
        entry_t r;
        r = e;
        if (we && (rd != '0) && (rd == e.rs_idx)) r.rs = data;
        if (we && (rd != '0) && (rd == e.rt_idx)) r.rt = data;
        return r;
    endfunction
`endif

    always_comb begin
        new_raw         = '0;
        new_raw.rs      = bus.in_rs_data;
        new_raw.rt      = bus.in_rt_data;
        new_raw.shamt   = dec_shamt;
        new_raw.shiftop = dec_shiftop;
        new_raw.rd      = dec_rd;
`ifdef SHIFT_FWD_EN
        new_raw.rs_idx  = RW'(bus.in_instr[25:21]);
        new_raw.rt_idx  = RW'(bus.in_instr[20:16]);
        new_d   = fwd_apply(new_raw, fwd_we, fwd_rd, fwd_data);
        out_fw  = fwd_apply(out_q,   fwd_we, fwd_rd, fwd_data);
        skid_fw = fwd_apply(skid_q,  fwd_we, fwd_rd, fwd_data);
`else
        new_d   = new_raw;
        out_fw  = out_q;
        skid_fw = skid_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BUF_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            drop_q      <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state_q     <= BUF_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= drop_d;
            out_q  <= out_fw;
            skid_q <= skid_fw;
            case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        out_q       <= new_d;
                        state_q     <= BUF_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (push && !pop) begin
                        skid_q     <= new_d;
                        state_q    <= BUF_TWO;
                        in_ready_q <= 1'b0;
                    end else if (push && pop) begin
                        out_q <= new_d;
                    end else if (pop) begin
                        state_q     <= BUF_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                BUF_TWO: begin
                    // in_ready is low here, so only the skid->output move can happen
                    if (pop) begin
                        out_q      <= skid_fw;
                        state_q    <= BUF_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= BUF_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rs      = out_q.rs;
    assign bus.out_rt      = out_q.rt;
    assign bus.out_shamt   = out_q.shamt;
    assign bus.out_shiftop = out_q.shiftop;
    assign bus.out_rd      = out_q.rd;
    assign drop_pulse      = drop_q;
endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage (SHIFT_FWD_EN steps included when defined).
module tb_shift_issue_stage;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst, flush, drop_pulse;
`ifdef SHIFT_FWD_EN
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif
    int n_chk = 0;
    int n_fail = 0;

    shift_issue_stage_if #(.DW(32), .RW(5)) bus ();

    shift_issue_stage #(.DW(32), .RW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .drop_pulse (drop_pulse)
`ifdef SHIFT_FWD_EN
        ,
        .fwd_we     (fwd_we),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sa, fn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
        bus.in_valid   = 1'b1;
        bus.in_instr   = ins;
        bus.in_rs_data = rsd;
        bus.in_rt_data = rtd;
    endtask

    logic [2:0] ops [6];

    initial begin
        ops = '{SHIFTOP_SLL, SHIFTOP_SRL, SHIFTOP_SRA, SHIFTOP_SLLV, SHIFTOP_SRLV, SHIFTOP_SRAV};
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_rs_data = '0; bus.in_rt_data = '0;
        bus.out_ready = 1'b0;
`ifdef SHIFT_FWD_EN
        fwd_we = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_out_rs", bus.out_rs, 0);
        chk("rst_out_rt", bus.out_rt, 0);
        chk("rst_shamt", bus.out_shamt, 0);
        chk("rst_shiftop", bus.out_shiftop, 0);
        chk("rst_rd", bus.out_rd, 0);

        // single SLL issue
        bus.out_ready = 1'b1;
        send(32'h00031180, 32'hff00f000, 32'hff000002);
        tick();
        bus.in_valid = 1'b0;
        chk("single_valid", bus.out_valid, 1);
        chk("single_shiftop", bus.out_shiftop, 3'b000);
        chk("single_shamt", bus.out_shamt, 6);
        chk("single_rd", bus.out_rd, 2);
        chk("single_rt", bus.out_rt, 32'hff000002);
        chk("single_rs", bus.out_rs, 32'hff00f000);
        chk("single_drop", drop_pulse, 0);
        tick();
        chk("single_drained", bus.out_valid, 0);

        // back-to-back six shift classes
        for (int i = 0; i < 6; i++) begin
            send(rtype(5'd1, 5'd2, 5'(i + 1), 5'(i), {3'b000, ops[i]}), 32'(i), 32'(i + 100));
            tick();
            chk("b2b_valid", bus.out_valid, 1);
            chk("b2b_shiftop", bus.out_shiftop, ops[i]);
            chk("b2b_rd", bus.out_rd, i + 1);
            chk("b2b_rs", bus.out_rs, i);
            chk("b2b_in_ready", bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("b2b_drained", bus.out_valid, 0);

        // stall: fill to TWO, hold third upstream, then drain in order
        bus.out_ready = 1'b0;
        send(rtype(5'd1, 5'd2, 5'd10, 5'd1, FUNCT_SRL), 32'h10, 32'h20);
        tick();
        chk("stall_a_ready", bus.in_ready, 1);
        chk("stall_a_rd", bus.out_rd, 10);
        send(rtype(5'd1, 5'd2, 5'd11, 5'd2, FUNCT_SRA), 32'h11, 32'h21);
        tick();
        chk("stall_two_ready", bus.in_ready, 0);
        chk("stall_two_rd", bus.out_rd, 10);
        send(rtype(5'd1, 5'd2, 5'd12, 5'd3, FUNCT_SLLV), 32'h12, 32'h22);
        tick();
        chk("stall_hold_ready", bus.in_ready, 0);
        chk("stall_hold_rd", bus.out_rd, 10);
        chk("stall_hold_shiftop", bus.out_shiftop, SHIFTOP_SRL);
        bus.out_ready = 1'b1;
        tick();
        chk("drain_b_rd", bus.out_rd, 11);
        chk("drain_b_ready", bus.in_ready, 1);
        chk("drain_b_valid", bus.out_valid, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("drain_c_rd", bus.out_rd, 12);
        chk("drain_c_rs", bus.out_rs, 32'h12);
        tick();
        chk("drain_empty", bus.out_valid, 0);

        // drops: NOP, ADD, funct 001
        send(32'h00000000, 32'h1, 32'h2);
        tick();
        chk("drop_nop_pulse", drop_pulse, 1);
        chk("drop_nop_valid", bus.out_valid, 0);
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'h1, 32'h2);
        tick();
        chk("drop_add_pulse", drop_pulse, 1);
        chk("drop_add_valid", bus.out_valid, 0);
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b000001), 32'h1, 32'h2);
        tick();
        bus.in_valid = 1'b0;
        chk("drop_f001_pulse", drop_pulse, 1);
        tick();
        chk("drop_idle_pulse", drop_pulse, 0);
        chk("drop_idle_valid", bus.out_valid, 0);

        // flush in TWO with a simultaneous request
        bus.out_ready = 1'b0;
        send(rtype(5'd1, 5'd2, 5'd20, 5'd0, FUNCT_SLL), 32'h0, 32'h0);
        tick();
        send(rtype(5'd1, 5'd2, 5'd21, 5'd0, FUNCT_SLL), 32'h0, 32'h0);
        tick();
        chk("flush_pre_ready", bus.in_ready, 0);
        flush = 1'b1;
        send(rtype(5'd1, 5'd2, 5'd22, 5'd0, FUNCT_SLL), 32'h0, 32'h0);
        tick();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_ready", bus.in_ready, 1);
        chk("flush_drop", drop_pulse, 0);
        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'h0, 32'h0);
        tick();
        chk("flush_add_drop", drop_pulse, 0);
        chk("flush_add_valid", bus.out_valid, 0);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("flush_after_drop", drop_pulse, 0);

        // reset mid-stall
        send(rtype(5'd1, 5'd2, 5'd23, 5'd4, FUNCT_SRAV), 32'h5, 32'h6);
        tick();
        send(rtype(5'd1, 5'd2, 5'd24, 5'd4, FUNCT_SRAV), 32'h5, 32'h6);
        tick();
        chk("rstmid_pre_ready", bus.in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rstmid_valid", bus.out_valid, 0);
        chk("rstmid_ready", bus.in_ready, 1);
        chk("rstmid_drop", drop_pulse, 0);
        chk("rstmid_rd", bus.out_rd, 0);

`ifdef SHIFT_FWD_EN
        bus.out_ready = 1'b1;
        fwd_we = 1'b1; fwd_rd = 5'd4; fwd_data = 32'h0000001f;
        send(rtype(5'd4, 5'd5, 5'd7, 5'd0, FUNCT_SLLV), 32'h12345678, 32'h9);
        tick();
        chk("fwd_hit_rs", bus.out_rs, 32'h0000001f);
        chk("fwd_hit_rt", bus.out_rt, 32'h9);
        fwd_rd = 5'd0;
        send(rtype(5'd0, 5'd5, 5'd7, 5'd0, FUNCT_SLLV), 32'h12345678, 32'h9);
        tick();
        chk("fwd_r0_rs", bus.out_rs, 32'h12345678);
        fwd_we = 1'b0;
        bus.in_valid = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
